// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host definitions: FSM states, frame size and common keyboard commands.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between control logic (master) and the PS/2 transmitter (slave).
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_valid, tx_data, input  tx_ready, busy, done, err);
  modport slave  (input  tx_valid, tx_data, output tx_ready, busy, done, err);
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// 2-FF synchronizer for one PS/2 line with a falling-edge strobe on the synced level.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  // Idle bus is pulled high, so reset to 1 to avoid a false edge after reset.
  logic [2:0] sh_q;

  always_ff @(posedge clk) begin
    if (rst) sh_q <= 3'b111;
    else     sh_q <= {sh_q[1:0], line_i};
  end

  assign sync_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one byte on device clocks, checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int START_SETUP    = 200,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   req,
  input  logic           ps2_c_in,
  input  logic           ps2_d_in,
  output logic           ps2_c_oe,
  output logic           ps2_d_oe
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          c_oe_q, c_oe_d;
  logic          d_oe_q, d_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic c_sync, c_fall, d_sync, d_fall;

  ps2_line_sync u_sync_c (.clk(clk), .rst(rst), .line_i(ps2_c_in), .sync_o(c_sync), .fall_o(c_fall));
  ps2_line_sync u_sync_d (.clk(clk), .rst(rst), .line_i(ps2_d_in), .sync_o(d_sync), .fall_o(d_fall));

  logic tmo;
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      c_oe_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      c_oe_q   <= c_oe_d;
      d_oe_q   <= d_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    c_oe_d   = c_oe_q;
    d_oe_d   = d_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        if (req.tx_valid) begin
          shreg_d  = {1'b1, odd_parity(req.tx_data), req.tx_data};
          cnt_d    = '0;
          bitcnt_d = '0;
          c_oe_d   = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        // Set one cycle early so the registered data pull is visible at count I-S.
        if (cnt_q == CW'(INHIBIT_CYCLES - START_SETUP - 1)) d_oe_d = 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (c_fall) begin
          d_oe_d   = ~shreg_q[0];
          shreg_d  = {1'b0, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          cnt_d    = '0;
          if (bitcnt_q == 4'(PS2_FRAME_BITS - 2)) state_d = ACK;
        end else if (tmo) begin
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ACK: begin
        d_oe_d = 1'b0;
        if (c_fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          cnt_d    = '0;
          if (d_sync) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (c_sync && d_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Data-line edges carry no meaning for the host side; only the level is used.
  logic unused_d_fall;
  assign unused_d_fall = d_fall;

  assign req.tx_ready = (state_q == IDLE);
  assign req.busy     = (state_q != IDLE);
  assign req.done     = done_q;
  assign req.err      = err_q;
  assign ps2_c_oe     = c_oe_q;
  assign ps2_d_oe     = d_oe_q;

endmodule
